// File: rtl/cpu_pkg.sv
// Shared sequencer types: FSM state encoding, opcode width, halt opcode,
// and the state-to-phase-strobe map used by timing_sequencer.
package cpu_pkg;

    localparam int OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PH1,
        S_PH2,
        S_PH3,
        S_PH4,
        S_PAUSE,
        S_HALTED
    } seq_state_e;

    // {T4,T3,T2,T1} for a given state; one-hot in PH1..PH4, zero elsewhere
    function automatic logic [3:0] phase_strobes(input seq_state_e s);
        logic [3:0] t;
        t = 4'b0000;
        unique case (s)
            S_PH1:   t = 4'b0001;
            S_PH2:   t = 4'b0010;
            S_PH3:   t = 4'b0100;
            S_PH4:   t = 4'b1000;
            default: t = 4'b0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/seq_pc_reg.sv
// Program counter: sync active-high reset to 0, advances once per
// instruction (increment with wrap, or load of branch target).
//   clk, reset           : clock, synchronous active-high reset
//   advance              : end of PH4, PC takes its next value
//   load, target         : select branch target instead of PC+1
//   pc                   : current program counter
module seq_pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Natural overflow of the PC_W-bit add gives the wrap to 0
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            pc_d = load ? target : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/timing_sequencer.sv
// Instruction fetch and T1..T4 phase sequencer feeding the opcode decoder.
// Ports: clk/Reset (sync, active-high); Run; fetch handshake InstrReq,
//   InstrAddr, InstrValid, InstrData; MemWait stretches T3; PCupdate and
//   Target load the branch target in T4; T1..T4 strobes; latched Opcode,
//   Operand; Halted; Step (single-step pulse).
// Build option: define SINGLE_STEP_EN to add a PAUSE state after each
//   non-halt instruction, released by Step. Undefined: Step is ignored.
module timing_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_W    = 8,
    parameter int                  INSTR_W = 16,
    parameter logic [OPCODE_W-1:0] HALT_OP = HALT_OPCODE
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        Run,
    output logic                        InstrReq,
    output logic [PC_W-1:0]             InstrAddr,
    input  logic                        InstrValid,
    input  logic [INSTR_W-1:0]          InstrData,
    input  logic                        MemWait,
    input  logic                        PCupdate,
    input  logic [PC_W-1:0]             Target,
    output logic                        T1,
    output logic                        T2,
    output logic                        T3,
    output logic                        T4,
    output logic [OPCODE_W-1:0]         Opcode,
    output logic [INSTR_W-OPCODE_W-1:0] Operand,
    output logic                        Halted,
    input  logic                        Step
);

    localparam int OPND_W = INSTR_W - OPCODE_W;

    seq_state_e          state_q,   state_d;
    logic [OPCODE_W-1:0] opcode_q,  opcode_d;
    logic [OPND_W-1:0]   operand_q, operand_d;
    logic [3:0]          t_q,       t_d;
    logic                req_q,     req_d;
    logic                halted_q,  halted_d;
    logic [PC_W-1:0]     pc;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (InstrValid) begin
                    opcode_d  = InstrData[INSTR_W-1 -: OPCODE_W];
                    operand_d = InstrData[OPND_W-1:0];
                    state_d   = S_PH1;
                end
            end
            S_PH1: state_d = S_PH2;
            S_PH2: state_d = S_PH3;
            S_PH3: begin
                if (!MemWait) state_d = S_PH4;
            end
            S_PH4: begin
                if (opcode_q == HALT_OP) begin
                    state_d = S_HALTED;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_d = S_PAUSE;
`else
                    state_d = Run ? S_FETCH : S_IDLE;
`endif
                end
            end
            S_PAUSE: begin
`ifdef SINGLE_STEP_EN
                if (Step) state_d = S_FETCH;
`else
                // Unreachable in this build; recover to a legal state
                state_d = Step ? S_FETCH : S_IDLE;
`endif
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // Outputs registered from the next state so they align with it
        t_d      = phase_strobes(state_d);
        req_d    = (state_d == S_FETCH);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            t_q       <= '0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            t_q       <= t_d;
            req_q     <= req_d;
            halted_q  <= halted_d;
        end
    end

    seq_pc_reg #(
        .PC_W (PC_W)
    ) u_pc (
        .clk     (clk),
        .reset   (Reset),
        .advance (state_q == S_PH4),
        .load    (PCupdate),
        .target  (Target),
        .pc      (pc)
    );

    assign InstrReq  = req_q;
    assign InstrAddr = pc;
    assign T1        = t_q[0];
    assign T2        = t_q[1];
    assign T3        = t_q[2];
    assign T4        = t_q[3];
    assign Opcode    = opcode_q;
    assign Operand   = operand_q;
    assign Halted    = halted_q;

endmodule
